// File: rtl/alu_stage_if.sv
// ALU stage bus: operand/op request from the sequencer and the registered
// result/flag bundle returned to the accumulator and status register.
//   master: drives alu_start/alu_op/opa/opb/carry_in/dec_mode, receives results
//   slave : the ALU stage itself
interface alu_stage_if;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned OP_W   = 4;
    localparam int unsigned FLAG_W = 4;

    logic              alu_start;
    logic [OP_W-1:0]   alu_op;
    logic [DATA_W-1:0] opa;
    logic [DATA_W-1:0] opb;
    logic              carry_in;
    logic              dec_mode;
    logic [DATA_W-1:0] ALU;
    logic [FLAG_W-1:0] flags;
    logic [FLAG_W-1:0] flags_upd;
    logic              result_wr;
    logic              alu_valid;
    logic              busy;

    modport master (
        output alu_start, alu_op, opa, opb, carry_in, dec_mode,
        input  ALU, flags, flags_upd, result_wr, alu_valid, busy
    );

    modport slave (
        input  alu_start, alu_op, opa, opb, carry_in, dec_mode,
        output ALU, flags, flags_upd, result_wr, alu_valid, busy
    );
endinterface

// File: rtl/alu_stage.sv
// Registered 6502 ALU stage feeding the accumulator and status register.
// Latches operands on alu_start when idle, computes one of the ALU ops, and
// presents result/flags/update-mask with a one-cycle alu_valid pulse.
// Optional BCD adjust cycle for ADC/SBC when DECIMAL_EN=1 and dec_mode=1.
//   clk   : core clock, rising edge
//   reset : asynchronous, active-high
//   bus   : alu_stage_if slave (request in, registered result out)
module alu_stage #(
    parameter bit DECIMAL_EN = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    alu_stage_if.slave  bus
);
    localparam int unsigned DATA_W = 8;
    localparam int unsigned OP_W   = 4;
    localparam int unsigned FLAG_W = 4;

    localparam logic [OP_W-1:0] OP_ORA = 4'd0;
    localparam logic [OP_W-1:0] OP_AND = 4'd1;
    localparam logic [OP_W-1:0] OP_EOR = 4'd2;
    localparam logic [OP_W-1:0] OP_ADC = 4'd3;
    localparam logic [OP_W-1:0] OP_SBC = 4'd4;
    localparam logic [OP_W-1:0] OP_CMP = 4'd5;
    localparam logic [OP_W-1:0] OP_ASL = 4'd6;
    localparam logic [OP_W-1:0] OP_LSR = 4'd7;
    localparam logic [OP_W-1:0] OP_ROL = 4'd8;
    localparam logic [OP_W-1:0] OP_ROR = 4'd9;
    localparam logic [OP_W-1:0] OP_INC = 4'd10;
    localparam logic [OP_W-1:0] OP_DEC = 4'd11;
    localparam logic [OP_W-1:0] OP_BIT = 4'd12;
    localparam logic [OP_W-1:0] OP_PAS = 4'd13;

    typedef enum logic [1:0] {IDLE, EXEC, ADJ} state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] a_q, b_q;
    logic              c_q, d_q;
    logic [OP_W-1:0]   op_q;
    logic              capture;

    logic [DATA_W-1:0] alu_q, alu_d;
    logic [FLAG_W-1:0] flags_q, flags_d;
    logic [FLAG_W-1:0] upd_q, upd_d;
    logic              wr_q, wr_d;
    logic              valid_q, valid_d;
    logic              busy_q, busy_d;

    // Shared adders: ADC, SBC (A + ~B + C) and CMP (A - B)
    logic [DATA_W:0] add9, sub9, cmp9;
    assign add9 = {1'b0, a_q} + {1'b0, b_q} + 9'(c_q);
    assign sub9 = {1'b0, a_q} + {1'b0, ~b_q} + 9'(c_q);
    assign cmp9 = {1'b0, a_q} + {1'b0, ~b_q} + 9'd1;

    // Binary result, flags, update mask and write enable
    logic [DATA_W-1:0] bin_res;
    logic              bin_n, bin_v, bin_z, bin_c;
    logic [FLAG_W-1:0] bin_mask;
    logic              bin_wr;

    always_comb begin
        bin_res  = a_q;
        bin_v    = 1'b0;
        bin_c    = 1'b0;
        bin_mask = 4'b0000;
        bin_wr   = 1'b1;
        case (op_q)
            OP_ORA: begin bin_res = a_q | b_q; bin_mask = 4'b1010; end
            OP_AND: begin bin_res = a_q & b_q; bin_mask = 4'b1010; end
            OP_EOR: begin bin_res = a_q ^ b_q; bin_mask = 4'b1010; end
            OP_ADC: begin
                bin_res  = add9[7:0];
                bin_c    = add9[8];
                bin_v    = (a_q[7] == b_q[7]) && (add9[7] != a_q[7]);
                bin_mask = 4'b1111;
            end
            OP_SBC: begin
                bin_res  = sub9[7:0];
                bin_c    = sub9[8];
                bin_v    = (a_q[7] != b_q[7]) && (sub9[7] != a_q[7]);
                bin_mask = 4'b1111;
            end
            OP_CMP: begin
                bin_res  = cmp9[7:0];
                bin_c    = cmp9[8];
                bin_wr   = 1'b0;
                bin_mask = 4'b1011;
            end
            OP_ASL: begin bin_res = {b_q[6:0], 1'b0}; bin_c = b_q[7]; bin_mask = 4'b1011; end
            OP_LSR: begin bin_res = {1'b0, b_q[7:1]}; bin_c = b_q[0]; bin_mask = 4'b1011; end
            OP_ROL: begin bin_res = {b_q[6:0], c_q};  bin_c = b_q[7]; bin_mask = 4'b1011; end
            OP_ROR: begin bin_res = {c_q, b_q[7:1]};  bin_c = b_q[0]; bin_mask = 4'b1011; end
            OP_INC: begin bin_res = b_q + 8'd1; bin_mask = 4'b1010; end
            OP_DEC: begin bin_res = b_q - 8'd1; bin_mask = 4'b1010; end
            OP_BIT: begin
                bin_res  = a_q & b_q;
                bin_v    = b_q[6];
                bin_wr   = 1'b0;
                bin_mask = 4'b1110;
            end
            OP_PAS: begin bin_res = b_q; bin_mask = 4'b1010; end
            default: begin bin_res = a_q; bin_wr = 1'b0; bin_mask = 4'b0000; end
        endcase
        // BIT takes N from the memory operand, everything else from the result
        bin_n = (op_q == OP_BIT) ? b_q[7] : bin_res[7];
        bin_z = (bin_res == 8'h00);
    end

    // BCD correction of the binary sum/difference (used only in ADJ)
    logic [4:0]        lo_add, lo_sub;
    logic [DATA_W+1:0] dec_t;
    logic [DATA_W-1:0] bcd_res;
    logic              bcd_c;

    always_comb begin
        lo_add  = {1'b0, a_q[3:0]} + {1'b0, b_q[3:0]} + 5'(c_q);
        lo_sub  = {1'b0, a_q[3:0]} + {1'b0, ~b_q[3:0]} + 5'(c_q);
        dec_t   = {1'b0, add9} + ((lo_add > 5'd9) ? 10'h006 : 10'h000);
        bcd_res = dec_t[7:0];
        bcd_c   = 1'b0;
        if (op_q == OP_ADC) begin
            if ((dec_t > 10'h099) || add9[8]) begin
                bcd_res = dec_t[7:0] + 8'h60;
                bcd_c   = 1'b1;
            end
        end else begin
            // No carry out of a nibble means that nibble borrowed
            bcd_res = sub9[7:0] - (lo_sub[4] ? 8'h00 : 8'h06) - (sub9[8] ? 8'h00 : 8'h60);
            bcd_c   = sub9[8];
        end
    end

    // State and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= 1'b0;
            d_q     <= 1'b0;
            op_q    <= '0;
            alu_q   <= '0;
            flags_q <= '0;
            upd_q   <= '0;
            wr_q    <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (capture) begin
                a_q  <= bus.opa;
                b_q  <= bus.opb;
                c_q  <= bus.carry_in;
                d_q  <= bus.dec_mode;
                op_q <= bus.alu_op;
            end
            alu_q   <= alu_d;
            flags_q <= flags_d;
            upd_q   <= upd_d;
            wr_q    <= wr_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        alu_d   = alu_q;
        flags_d = flags_q;
        upd_d   = upd_q;
        wr_d    = wr_q;
        valid_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.alu_start) begin
                    capture = 1'b1;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (DECIMAL_EN && d_q && ((op_q == OP_ADC) || (op_q == OP_SBC))) begin
                    state_d = ADJ;
                end else begin
                    alu_d   = bin_res;
                    flags_d = {bin_n, bin_v, bin_z, bin_c};
                    upd_d   = bin_mask;
                    wr_d    = bin_wr;
                    valid_d = 1'b1;
                    state_d = IDLE;
                end
            end
            ADJ: begin
                // N/V/Z stay binary, only the value and carry are decimal
                alu_d   = bcd_res;
                flags_d = {bin_n, bin_v, bin_z, bcd_c};
                upd_d   = 4'b1111;
                wr_d    = 1'b1;
                valid_d = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    assign bus.ALU       = alu_q;
    assign bus.flags     = flags_q;
    assign bus.flags_upd = upd_q;
    assign bus.result_wr = wr_q;
    assign bus.alu_valid = valid_q;
    assign bus.busy      = busy_q;
endmodule

// File: tb/tb_alu_stage.sv
// Scoreboard bench for alu_stage: one instance with the BCD cycle enabled and
// one without, both driven by the same request stream.
module tb_alu_stage;
    typedef struct packed {
        logic [7:0] alu;
        logic [3:0] flags;
        logic [3:0] mask;
        logic       wr;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [3:0] op = 4'd0;
    logic [7:0] a = 8'h00;
    logic [7:0] b = 8'h00;
    logic       cin = 1'b0;
    logic       dm = 1'b0;

    int checks = 0;
    int failures = 0;
    exp_t q_dec[$];
    exp_t q_bin[$];
    exp_t ed, eb;

    always #5 clk = ~clk;

    alu_stage_if bus_d ();
    alu_stage_if bus_b ();

    assign bus_d.alu_start = start;
    assign bus_d.alu_op    = op;
    assign bus_d.opa       = a;
    assign bus_d.opb       = b;
    assign bus_d.carry_in  = cin;
    assign bus_d.dec_mode  = dm;
    assign bus_b.alu_start = start;
    assign bus_b.alu_op    = op;
    assign bus_b.opa       = a;
    assign bus_b.opb       = b;
    assign bus_b.carry_in  = cin;
    assign bus_b.dec_mode  = dm;

    alu_stage #(.DECIMAL_EN(1'b1)) dut_d (.clk(clk), .reset(reset), .bus(bus_d));
    alu_stage #(.DECIMAL_EN(1'b0)) dut_b (.clk(clk), .reset(reset), .bus(bus_b));

    // Reference model written in integer arithmetic
    function automatic exp_t model(input int o, input int x, input int y, input int c,
                                   input int d, input bit dec_en);
        exp_t e;
        int r, s, t, lo, n, v, cf, z, mask, wr;
        r = x; s = 0; v = 0; cf = 0; mask = 0; wr = 1;
        case (o)
            0: begin r = x | y; mask = 10; end
            1: begin r = x & y; mask = 10; end
            2: begin r = x ^ y; mask = 10; end
            3: begin s = x + y + c; r = s % 256; cf = (s > 255) ? 1 : 0;
                     v = (((x ^ y) & 128) == 0 && ((x ^ r) & 128) != 0) ? 1 : 0; mask = 15; end
            4: begin s = x + (255 - y) + c; r = s % 256; cf = (s > 255) ? 1 : 0;
                     v = (((x ^ y) & 128) != 0 && ((x ^ r) & 128) != 0) ? 1 : 0; mask = 15; end
            5: begin r = (x - y + 256) % 256; cf = (x >= y) ? 1 : 0; wr = 0; mask = 11; end
            6: begin r = (y * 2) % 256; cf = y / 128; mask = 11; end
            7: begin r = y / 2; cf = y % 2; mask = 11; end
            8: begin r = (y * 2) % 256 + c; cf = y / 128; mask = 11; end
            9: begin r = c * 128 + y / 2; cf = y % 2; mask = 11; end
            10: begin r = (y + 1) % 256; mask = 10; end
            11: begin r = (y + 255) % 256; mask = 10; end
            12: begin r = x & y; v = (y / 64) % 2; wr = 0; mask = 14; end
            13: begin r = y; mask = 10; end
            default: begin r = x; wr = 0; mask = 0; end
        endcase
        n = (o == 12) ? y / 128 : r / 128;
        z = (r == 0) ? 1 : 0;
        if (dec_en && d != 0 && o == 3) begin
            lo = (x % 16) + (y % 16) + c;
            t = s;
            if (lo > 9) t = t + 6;
            if (t > 153 || s > 255) begin t = t + 96; cf = 1; end
            else cf = 0;
            r = t % 256;
        end else if (dec_en && d != 0 && o == 4) begin
            lo = (x % 16) + (15 - y % 16) + c;
            t = s % 256;
            if (lo < 16) t = t - 6;
            if (s < 256) t = t - 96;
            r = (t + 512) % 256;
        end
        e.alu   = 8'(r);
        e.flags = {1'(n), 1'(v), 1'(z), 1'(cf)};
        e.mask  = 4'(mask);
        e.wr    = 1'(wr);
        return e;
    endfunction

    // Scoreboard pop/compare on every valid pulse of either instance
    always @(negedge clk) begin
        if (bus_d.alu_valid === 1'b1) begin
            checks++;
            if (q_dec.size() == 0) begin
                failures++;
                $display("FAIL dec_unexpected_valid: got valid with empty queue, required none");
            end else begin
                ed = q_dec.pop_front();
                if ({bus_d.ALU, bus_d.flags & bus_d.flags_upd, bus_d.flags_upd, bus_d.result_wr}
                    !== {ed.alu, ed.flags & ed.mask, ed.mask, ed.wr}) begin
                    failures++;
                    $display("FAIL dec_result: got alu=%h flags=%b upd=%b wr=%b, required alu=%h flags=%b upd=%b wr=%b",
                             bus_d.ALU, bus_d.flags & bus_d.flags_upd, bus_d.flags_upd, bus_d.result_wr,
                             ed.alu, ed.flags & ed.mask, ed.mask, ed.wr);
                end
            end
        end
        if (bus_b.alu_valid === 1'b1) begin
            checks++;
            if (q_bin.size() == 0) begin
                failures++;
                $display("FAIL bin_unexpected_valid: got valid with empty queue, required none");
            end else begin
                eb = q_bin.pop_front();
                if ({bus_b.ALU, bus_b.flags & bus_b.flags_upd, bus_b.flags_upd, bus_b.result_wr}
                    !== {eb.alu, eb.flags & eb.mask, eb.mask, eb.wr}) begin
                    failures++;
                    $display("FAIL bin_result: got alu=%h flags=%b upd=%b wr=%b, required alu=%h flags=%b upd=%b wr=%b",
                             bus_b.ALU, bus_b.flags & bus_b.flags_upd, bus_b.flags_upd, bus_b.result_wr,
                             eb.alu, eb.flags & eb.mask, eb.mask, eb.wr);
                end
            end
        end
    end

    task automatic issue(input int o, input int x, input int y, input int c, input int d);
        q_dec.push_back(model(o, x, y, c, d, 1'b1));
        q_bin.push_back(model(o, x, y, c, d, 1'b0));
        op = 4'(o); a = 8'(x); b = 8'(y); cin = 1'(c); dm = 1'(d);
        start = 1'b1;
    endtask

    // Latency = number of falling edges from the start drive to the valid pulse
    task automatic wait_valid(output int ld, output int lb);
        ld = -1; lb = -1;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (i == 1) start = 1'b0;
            if (bus_d.alu_valid === 1'b1 && ld < 0) ld = i;
            if (bus_b.alu_valid === 1'b1 && lb < 0) lb = i;
            if (ld >= 0 && lb >= 0) break;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus_d.ALU, bus_d.flags, bus_d.flags_upd, bus_d.result_wr, bus_d.alu_valid, bus_d.busy} !== 19'h0) begin
            failures++;
            $display("FAIL reset_dec: got %h, required 0",
                     {bus_d.ALU, bus_d.flags, bus_d.flags_upd, bus_d.result_wr, bus_d.alu_valid, bus_d.busy});
        end
        checks++;
        if ({bus_b.ALU, bus_b.flags, bus_b.flags_upd, bus_b.result_wr, bus_b.alu_valid, bus_b.busy} !== 19'h0) begin
            failures++;
            $display("FAIL reset_bin: got %h, required 0",
                     {bus_b.ALU, bus_b.flags, bus_b.flags_upd, bus_b.result_wr, bus_b.alu_valid, bus_b.busy});
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_arith();
        int ld, lb;
        issue(3, 'h50, 'h50, 0, 0);
        wait_valid(ld, lb);
        checks++;
        if (lb != 2 || ld != 2) begin failures++; $display("FAIL adc_latency: got %0d/%0d, required 2/2", ld, lb); end
        checks++;
        if ({bus_b.ALU, bus_b.flags, bus_b.flags_upd} !== {8'hA0, 4'b1100, 4'b1111}) begin
            failures++;
            $display("FAIL adc_5050: got %h %b %b, required a0 1100 1111", bus_b.ALU, bus_b.flags, bus_b.flags_upd);
        end
        issue(4, 'h00, 'h01, 1, 0);
        wait_valid(ld, lb);
        checks++;
        if ({bus_b.ALU, bus_b.flags} !== {8'hFF, 4'b1000}) begin
            failures++;
            $display("FAIL sbc_0001: got %h %b, required ff 1000", bus_b.ALU, bus_b.flags);
        end
        issue(5, 'h10, 'h10, 0, 0);
        wait_valid(ld, lb);
        checks++;
        if ({bus_b.ALU, bus_b.flags & 4'b1011, bus_b.result_wr} !== {8'h00, 4'b0011, 1'b0}) begin
            failures++;
            $display("FAIL cmp_equal: got %h %b wr=%b, required 00 0011 wr=0",
                     bus_b.ALU, bus_b.flags & 4'b1011, bus_b.result_wr);
        end
    endtask

    task automatic test_shift_incdec();
        int ld, lb;
        issue(9, 'h00, 'h01, 1, 0);
        wait_valid(ld, lb);
        checks++;
        if ({bus_b.ALU, bus_b.flags & 4'b1011} !== {8'h80, 4'b1001}) begin
            failures++;
            $display("FAIL ror_01: got %h %b, required 80 1001", bus_b.ALU, bus_b.flags & 4'b1011);
        end
        issue(7, 'h00, 'h01, 0, 0);
        wait_valid(ld, lb);
        checks++;
        if ({bus_b.ALU, bus_b.flags & 4'b1011} !== {8'h00, 4'b0011}) begin
            failures++;
            $display("FAIL lsr_01: got %h %b, required 00 0011", bus_b.ALU, bus_b.flags & 4'b1011);
        end
        issue(11, 'h00, 'h00, 0, 0);
        wait_valid(ld, lb);
        checks++;
        if (bus_b.ALU !== 8'hFF) begin failures++; $display("FAIL dec_00: got %h, required ff", bus_b.ALU); end
        issue(10, 'h00, 'hFF, 0, 0); wait_valid(ld, lb);
        issue(12, 'h0F, 'hC0, 0, 0); wait_valid(ld, lb);
        issue(15, 'h5A, 'h00, 1, 0); wait_valid(ld, lb);
    endtask

    task automatic test_decimal();
        int ld, lb;
        issue(3, 'h19, 'h28, 0, 1);
        wait_valid(ld, lb);
        checks++;
        if (ld != 3 || lb != 2) begin failures++; $display("FAIL bcd_latency: got %0d/%0d, required 3/2", ld, lb); end
        checks++;
        if ({bus_d.ALU, bus_d.flags[0]} !== {8'h47, 1'b0}) begin
            failures++;
            $display("FAIL bcd_adc_dec: got %h c=%b, required 47 c=0", bus_d.ALU, bus_d.flags[0]);
        end
        checks++;
        if (bus_b.ALU !== 8'h41) begin failures++; $display("FAIL bcd_adc_bin: got %h, required 41", bus_b.ALU); end
        issue(4, 'h42, 'h13, 1, 1);
        wait_valid(ld, lb);
        checks++;
        if ({bus_d.ALU, bus_d.flags[0]} !== {8'h29, 1'b1}) begin
            failures++;
            $display("FAIL bcd_sbc_dec: got %h c=%b, required 29 c=1", bus_d.ALU, bus_d.flags[0]);
        end
        issue(0, 'h0F, 'hF0, 0, 1);
        wait_valid(ld, lb);
        checks++;
        if (ld != 2) begin failures++; $display("FAIL bcd_ora_latency: got %0d, required 2", ld); end
    endtask

    task automatic test_random();
        int ld, lb, o, d, want;
        for (int i = 0; i < 24; i++) begin
            o = int'($urandom_range(0, 15));
            d = int'($urandom_range(0, 1));
            issue(o, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), int'($urandom_range(0, 1)), d);
            wait_valid(ld, lb);
            want = (d == 1 && (o == 3 || o == 4)) ? 3 : 2;
            checks++;
            if (ld != want || lb != 2) begin
                failures++;
                $display("FAIL random_latency: op=%0d got %0d/%0d, required %0d/2", o, ld, lb, want);
            end
        end
    endtask

    task automatic test_back_to_back();
        int cnt_d, cnt_b;
        cnt_d = 0; cnt_b = 0;
        for (int k = 0; k < 6; k++) begin
            if (k % 2 == 0) begin
                issue(3, 16 * k + 3, 'h20 + k, k % 3 == 0 ? 1 : 0, 0);
            end else begin
                op = 4'd3; a = 8'(16 * k + 3); b = 8'('h20 + k); cin = 1'b1; start = 1'b1;
            end
            @(negedge clk);
            if (bus_d.alu_valid === 1'b1) cnt_d++;
            if (bus_b.alu_valid === 1'b1) cnt_b++;
        end
        start = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (bus_d.alu_valid === 1'b1) cnt_d++;
            if (bus_b.alu_valid === 1'b1) cnt_b++;
        end
        checks++;
        if (cnt_d != 3 || cnt_b != 3) begin
            failures++;
            $display("FAIL b2b_count: got %0d/%0d ops, required 3/3", cnt_d, cnt_b);
        end
    endtask

    task automatic test_reset_mid();
        int ld, lb;
        issue(3, 'h7F, 'h01, 0, 0);
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (bus_b.busy !== 1'b1) begin failures++; $display("FAIL mid_busy: got %b, required 1", bus_b.busy); end
        reset = 1'b1;
        #1;
        checks++;
        if ({bus_d.ALU, bus_d.flags, bus_d.flags_upd, bus_d.result_wr, bus_d.alu_valid, bus_d.busy,
             bus_b.ALU, bus_b.flags, bus_b.flags_upd, bus_b.result_wr, bus_b.alu_valid, bus_b.busy} !== 38'h0) begin
            failures++;
            $display("FAIL mid_reset_outputs: got alu=%h/%h busy=%b/%b, required all 0",
                     bus_d.ALU, bus_b.ALU, bus_d.busy, bus_b.busy);
        end
        void'(q_dec.pop_back());
        void'(q_bin.pop_back());
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        issue(3, 'h01, 'h01, 0, 0);
        wait_valid(ld, lb);
        checks++;
        if (ld != 2 || lb != 2 || bus_b.ALU !== 8'h02) begin
            failures++;
            $display("FAIL post_reset_op: got lat %0d/%0d alu=%h, required 2/2 alu=02", ld, lb, bus_b.ALU);
        end
    endtask

    initial begin
        test_reset();
        test_arith();
        test_shift_incdec();
        test_decimal();
        test_random();
        test_back_to_back();
        test_reset_mid();
        repeat (3) @(negedge clk);
        checks++;
        if (q_dec.size() != 0 || q_bin.size() != 0) begin
            failures++;
            $display("FAIL queue_drain: got %0d/%0d pending, required 0/0", q_dec.size(), q_bin.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
